// File: rtl/m3_pkg.sv
// -----------------------------------------------------------------------------
// m3_pkg
// Shared definitions for the M3 commutation step generator: FSM state
// encoding, step-length floor, dead-time length, last step index and the
// six-step gate drive table. Also provides the step-length clamp helper.
// Drive table entries are packed {hi[2:0], lo[2:0]}, each field ordered {W,V,U}.
// -----------------------------------------------------------------------------
package m3_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    localparam logic [31:0] STEP_LEN_MIN = 32'd40;
    localparam logic [3:0]  DEAD_CYCLES  = 4'd8;
    localparam logic [2:0]  STEP_LAST    = 3'd5;

    // step: 0 U/V, 1 U/W, 2 V/W, 3 V/U, 4 W/U, 5 W/V
    localparam logic [5:0] DRIVE_TABLE [6] = '{
        6'b001_010,
        6'b001_100,
        6'b010_100,
        6'b010_001,
        6'b100_001,
        6'b100_010
    };

    // Short step requests are raised to the minimum length; no arithmetic
    // is done on the raw input, so nothing can wrap.
    function automatic logic [31:0] clamp_len(input logic [31:0] len);
        return (len < STEP_LEN_MIN) ? STEP_LEN_MIN : len;
    endfunction

endpackage

// File: rtl/m3_step_decode.sv
// -----------------------------------------------------------------------------
// m3_step_decode
// Combinational step index -> gate pattern lookup.
// Ports:
//   i_stepIdx  [2:0]  step index 0..5 (other codes decode to all-off)
//   o_phaseHi  [2:0]  high-side gates {W,V,U}
//   o_phaseLo  [2:0]  low-side gates {W,V,U}
// -----------------------------------------------------------------------------
module m3_step_decode
    import m3_pkg::*;
(
    input  logic [2:0] i_stepIdx,
    output logic [2:0] o_phaseHi,
    output logic [2:0] o_phaseLo
);

    always_comb begin
        o_phaseHi = 3'b000;
        o_phaseLo = 3'b000;
        if (i_stepIdx <= STEP_LAST) begin
            o_phaseHi = DRIVE_TABLE[i_stepIdx][5:3];
            o_phaseLo = DRIVE_TABLE[i_stepIdx][2:0];
        end
    end

endmodule

// File: rtl/m3_phase_step_gen.sv
// -----------------------------------------------------------------------------
// m3_phase_step_gen
// Six-step BLDC commutation generator. Each step lasts L clocks, where
// L = max(roundLenI, 40) is sampled at the start of the step. Supports
// reverse rotation, a force-stop hold that freezes position with gates off,
// and a per-round pulse for the speed calculator.
//
// Ports:
//   clkI          system clock
//   nRstI         asynchronous active-low reset
//   workingI      enable; low returns to idle with everything off
//   m3forceStopI  gates off, step and counter frozen (HOLD)
//   m3invRotateI  1 = reverse step order, sampled at each step advance
//   roundLenI     [31:0] clocks per commutation step
//   phaseHiO      [2:0] high-side gates {W,V,U}
//   phaseLoO      [2:0] low-side gates {W,V,U}
//   stepIdxO      [2:0] current step 0..5
//   nextRoundO    one-cycle pulse on each completed electrical round
//   busyO         1 when not idle
//
// Build option: define M3_DEADTIME_EN to blank both gate sets for the first
// DEAD_CYCLES clocks of every step (step period unchanged).
// -----------------------------------------------------------------------------
module m3_phase_step_gen
    import m3_pkg::*;
(
    input  logic        clkI,
    input  logic        nRstI,
    input  logic        workingI,
    input  logic        m3forceStopI,
    input  logic        m3invRotateI,
    input  logic [31:0] roundLenI,
    output logic [2:0]  phaseHiO,
    output logic [2:0]  phaseLoO,
    output logic [2:0]  stepIdxO,
    output logic        nextRoundO,
    output logic        busyO
);

    state_t      r_state;
    logic [2:0]  r_stepIdx;
    logic [31:0] r_cnt;
    logic [2:0]  r_phaseHi;
    logic [2:0]  r_phaseLo;
    logic        r_nextRound;
    logic        r_busy;

    state_t      w_nextState;
    logic [2:0]  w_nextIdx;
    logic [2:0]  w_advIdx;
    logic [31:0] w_nextCnt;
    logic [31:0] w_reload;
    logic        w_drive;
    logic        w_round;
    logic        w_gate;
    logic [2:0]  w_tblHi;
    logic [2:0]  w_tblLo;

    always_comb begin
        w_reload = clamp_len(roundLenI) - 32'd1;
        if (m3invRotateI)
            w_advIdx = (r_stepIdx == 3'd0) ? STEP_LAST : r_stepIdx - 3'd1;
        else
            w_advIdx = (r_stepIdx == STEP_LAST) ? 3'd0 : r_stepIdx + 3'd1;
    end

    // Next-state logic. workingI low wins over every other input.
    always_comb begin
        w_nextState = r_state;
        w_nextIdx   = r_stepIdx;
        w_nextCnt   = r_cnt;
        w_drive     = 1'b0;
        w_round     = 1'b0;
        if (!workingI) begin
            w_nextState = ST_IDLE;
            w_nextIdx   = 3'd0;
            w_nextCnt   = 32'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (!m3forceStopI) begin
                        w_nextState = ST_RUN;
                        w_nextIdx   = 3'd0;
                        w_nextCnt   = w_reload;
                        w_drive     = 1'b1;
                    end
                end
                ST_RUN: begin
                    if (m3forceStopI) begin
                        // Freeze step and counter; gates go off.
                        w_nextState = ST_HOLD;
                    end else if (r_cnt == 32'd0) begin
                        w_nextIdx = w_advIdx;
                        w_nextCnt = w_reload;
                        w_drive   = 1'b1;
                        // A round completes when the sequence wraps in
                        // whichever direction it is turning.
                        w_round   = (!m3invRotateI && r_stepIdx == STEP_LAST) ||
                                    ( m3invRotateI && r_stepIdx == 3'd0);
                    end else begin
                        w_nextCnt = r_cnt - 32'd1;
                        w_drive   = 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (!m3forceStopI) begin
                        // Resume the held step with a full fresh period.
                        w_nextState = ST_RUN;
                        w_nextCnt   = w_reload;
                        w_drive     = 1'b1;
                    end
                end
                default: begin
                    w_nextState = ST_IDLE;
                    w_nextIdx   = 3'd0;
                    w_nextCnt   = 32'd0;
                end
            endcase
        end
    end

    // Decode the step that will be visible after the next edge so the gate
    // outputs can be registered alongside stepIdxO.
    m3_step_decode u_decode (
        .i_stepIdx (w_nextIdx),
        .o_phaseHi (w_tblHi),
        .o_phaseLo (w_tblLo)
    );

`ifdef M3_DEADTIME_EN
    logic [3:0] r_deadCnt;
    logic [3:0] w_nextDead;
    logic       w_stepStart;

    // A step starts on every driven edge except plain countdown in RUN.
    always_comb begin
        w_stepStart = w_drive && ((r_state != ST_RUN) || (r_cnt == 32'd0));
        if (w_stepStart)
            w_nextDead = DEAD_CYCLES;
        else if (r_deadCnt != 4'd0)
            w_nextDead = r_deadCnt - 4'd1;
        else
            w_nextDead = 4'd0;
        w_gate = w_drive && (w_nextDead == 4'd0);
    end

    always_ff @(posedge clkI or negedge nRstI) begin
        if (!nRstI)
            r_deadCnt <= 4'd0;
        else
            r_deadCnt <= w_nextDead;
    end
`else
    assign w_gate = w_drive;
`endif

    // Registered state and outputs.
    always_ff @(posedge clkI or negedge nRstI) begin
        if (!nRstI) begin
            r_state     <= ST_IDLE;
            r_stepIdx   <= 3'd0;
            r_cnt       <= 32'd0;
            r_phaseHi   <= 3'b000;
            r_phaseLo   <= 3'b000;
            r_nextRound <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_nextState;
            r_stepIdx   <= w_nextIdx;
            r_cnt       <= w_nextCnt;
            r_phaseHi   <= w_gate ? w_tblHi : 3'b000;
            r_phaseLo   <= w_gate ? w_tblLo : 3'b000;
            r_nextRound <= w_round;
            r_busy      <= (w_nextState != ST_IDLE);
        end
    end

    assign phaseHiO   = r_phaseHi;
    assign phaseLoO   = r_phaseLo;
    assign stepIdxO   = r_stepIdx;
    assign nextRoundO = r_nextRound;
    assign busyO      = r_busy;

endmodule

// File: tb/tb_m3_phase_step_gen.sv
// -----------------------------------------------------------------------------
// tb_m3_phase_step_gen
// Directed bench for m3_phase_step_gen: forward run, clamp, reverse,
// force-stop hold, workingI drop, async reset pulse. Expected step events are
// queued as stimulus is applied and compared as the DUT changes step.
// Honours M3_DEADTIME_EN to match a dead-time build of the design.
// -----------------------------------------------------------------------------
module tb_m3_phase_step_gen;

    logic        clkI;
    logic        nRstI;
    logic        workingI;
    logic        m3forceStopI;
    logic        m3invRotateI;
    logic [31:0] roundLenI;
    logic [2:0]  phaseHiO;
    logic [2:0]  phaseLoO;
    logic [2:0]  stepIdxO;
    logic        nextRoundO;
    logic        busyO;

    m3_phase_step_gen dut (
        .clkI         (clkI),
        .nRstI        (nRstI),
        .workingI     (workingI),
        .m3forceStopI (m3forceStopI),
        .m3invRotateI (m3invRotateI),
        .roundLenI    (roundLenI),
        .phaseHiO     (phaseHiO),
        .phaseLoO     (phaseLoO),
        .stepIdxO     (stepIdxO),
        .nextRoundO   (nextRoundO),
        .busyO        (busyO)
    );

    initial clkI = 1'b0;
    always #5 clkI = ~clkI;

    int cyc = 0;
    always @(posedge clkI) cyc <= cyc + 1;

    // Independent copy of the gate table, {hi,lo} with {W,V,U} ordering.
    logic [5:0] tbl [6] = '{6'b001_010, 6'b001_100, 6'b010_100,
                            6'b010_001, 6'b100_001, 6'b100_010};

    typedef struct {
        logic [2:0] idx;
        int         gap;
        logic       round;
    } rec_t;

    rec_t sb[$];
    int checks   = 0;
    int failures = 0;
    logic [2:0] last_idx;
    int prev_cyc;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Expected gate pattern for a step at a given age (cycles since step start).
    function automatic logic [5:0] pattern(input logic [2:0] idx, input int age);
`ifdef M3_DEADTIME_EN
        if (age < 8) return 6'b0;
`endif
        if (idx > 3'd5) return 6'b0;
        return tbl[idx];
    endfunction

    task automatic push_exp(input logic [2:0] idx, input int gap, input logic round);
        rec_t r;
        r.idx = idx;
        r.gap = gap;
        r.round = round;
        sb.push_back(r);
    endtask

    // Wait for the next step change, checking gates and nextRoundO on every
    // cycle of the current step, then compare against the queued record.
    task automatic pop_and_check();
        rec_t r;
        bit   got;
        bit   bad;
        r   = sb.pop_front();
        got = 1'b0;
        bad = 1'b0;
        for (int i = 0; i < 400 && !got; i++) begin
            @(negedge clkI);
            if (stepIdxO !== last_idx) begin
                got = 1'b1;
            end else begin
                if ({phaseHiO, phaseLoO} !== pattern(last_idx, cyc - prev_cyc)) bad = 1'b1;
                if ((phaseHiO & phaseLoO) !== 3'b000) bad = 1'b1;
                if (nextRoundO !== 1'b0) bad = 1'b1;
            end
        end
        check("step_change_seen", 32'(got), 32'd1);
        check("pattern_within_step", 32'(bad), 32'd0);
        if (got) begin
            check("step_idx", 32'(stepIdxO), 32'(r.idx));
            if (r.gap != 0) check("step_spacing", 32'(cyc - prev_cyc), 32'(r.gap));
            check("next_round", 32'(nextRoundO), 32'(r.round));
            check("drive_at_change", 32'({phaseHiO, phaseLoO}), 32'(pattern(r.idx, 0)));
            last_idx = stepIdxO;
            prev_cyc = cyc;
        end
    endtask

    task automatic drain();
        while (sb.size() > 0) pop_and_check();
    endtask

    initial begin
        nRstI        = 1'b0;
        workingI     = 1'b0;
        m3forceStopI = 1'b0;
        m3invRotateI = 1'b0;
        roundLenI    = 32'd100;
        last_idx     = 3'd0;
        prev_cyc     = 0;
        repeat (3) @(negedge clkI);

        // Reset state
        check("rst_step", 32'(stepIdxO), 32'd0);
        check("rst_hi", 32'(phaseHiO), 32'd0);
        check("rst_lo", 32'(phaseLoO), 32'd0);
        check("rst_round", 32'(nextRoundO), 32'd0);
        check("rst_busy", 32'(busyO), 32'd0);

        nRstI = 1'b1;
        @(negedge clkI);
        check("idle_not_busy", 32'(busyO), 32'd0);

        // Start: step 0 appears one edge after workingI rises
        workingI = 1'b1;
        @(negedge clkI);
        check("start_busy", 32'(busyO), 32'd1);
        check("start_step", 32'(stepIdxO), 32'd0);
        check("start_round", 32'(nextRoundO), 32'd0);
        check("start_drive", 32'({phaseHiO, phaseLoO}), 32'(pattern(3'd0, 0)));
        last_idx = 3'd0;
        prev_cyc = cyc;

        // Forward run, L=100
        for (int s = 1; s <= 5; s++) push_exp(3'(s), 100, 1'b0);
        push_exp(3'd0, 100, 1'b1);
        drain();

        // Clamp: current step keeps 100, later steps are 40
        roundLenI = 32'd10;
        push_exp(3'd1, 100, 1'b0);
        push_exp(3'd2, 40, 1'b0);
        drain();

        // Reverse from step 2
        m3invRotateI = 1'b1;
        push_exp(3'd1, 40, 1'b0);
        push_exp(3'd0, 40, 1'b0);
        push_exp(3'd5, 40, 1'b1);
        drain();

        // Back to forward, L=100 from the next step on
        roundLenI    = 32'd100;
        m3invRotateI = 1'b0;
        push_exp(3'd0, 40, 1'b1);
        push_exp(3'd1, 100, 1'b0);
        push_exp(3'd2, 100, 1'b0);
        push_exp(3'd3, 100, 1'b0);
        drain();

        // Force stop mid-step 3 for 50 cycles
        repeat (20) @(negedge clkI);
        m3forceStopI = 1'b1;
        @(negedge clkI);
        check("hold_hi", 32'(phaseHiO), 32'd0);
        check("hold_lo", 32'(phaseLoO), 32'd0);
        check("hold_step", 32'(stepIdxO), 32'd3);
        check("hold_busy", 32'(busyO), 32'd1);
        repeat (49) @(negedge clkI);
        check("hold_step_end", 32'(stepIdxO), 32'd3);
        check("hold_hi_end", 32'(phaseHiO), 32'd0);
        m3forceStopI = 1'b0;
        @(negedge clkI);
        check("resume_step", 32'(stepIdxO), 32'd3);
        check("resume_drive", 32'({phaseHiO, phaseLoO}), 32'(pattern(3'd3, 0)));
        last_idx = 3'd3;
        prev_cyc = cyc;
        push_exp(3'd4, 100, 1'b0);
        drain();

        // workingI low mid-step 4
        repeat (30) @(negedge clkI);
        workingI = 1'b0;
        @(negedge clkI);
        check("off_step", 32'(stepIdxO), 32'd0);
        check("off_hi", 32'(phaseHiO), 32'd0);
        check("off_lo", 32'(phaseLoO), 32'd0);
        check("off_busy", 32'(busyO), 32'd0);
        check("off_round", 32'(nextRoundO), 32'd0);
        repeat (3) @(negedge clkI);
        workingI = 1'b1;
        @(negedge clkI);
        check("restart_step", 32'(stepIdxO), 32'd0);
        check("restart_busy", 32'(busyO), 32'd1);
        check("restart_round", 32'(nextRoundO), 32'd0);
        check("restart_drive", 32'({phaseHiO, phaseLoO}), 32'(pattern(3'd0, 0)));
        last_idx = 3'd0;
        prev_cyc = cyc;
        push_exp(3'd1, 100, 1'b0);
        drain();

        // Async reset pulse mid-step 1
        repeat (30) @(negedge clkI);
        nRstI = 1'b0;
        #1;
        check("arst_step", 32'(stepIdxO), 32'd0);
        check("arst_hi", 32'(phaseHiO), 32'd0);
        check("arst_lo", 32'(phaseLoO), 32'd0);
        check("arst_busy", 32'(busyO), 32'd0);
        check("arst_round", 32'(nextRoundO), 32'd0);
        @(negedge clkI);
        nRstI = 1'b1;
        @(negedge clkI);
        check("rst_restart_step", 32'(stepIdxO), 32'd0);
        check("rst_restart_busy", 32'(busyO), 32'd1);
        check("rst_restart_round", 32'(nextRoundO), 32'd0);
        last_idx = 3'd0;
        prev_cyc = cyc;
        push_exp(3'd1, 100, 1'b0);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
